wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage and general register file of the 16-bit five-stage pipeline.
- Latches the MEM-stage instruction and result into the MEM/WB pipeline registers (wb_ir, reg_C1).
- Commits results into gr0..gr7 and supplies gr0..gr7 and the WB forwarding sources to the decode stage.
- Also keeps a retired-instruction counter and a halt flag for the control unit and debug.

Parameters:
- RETIRE_W, 16, width of the retired-instruction counter (wraps modulo 2^RETIRE_W).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- state  in  1  CPU run state; pipeline advances only when state == `exec.
- mem_ir  in  16  instruction in the MEM stage.
- reg_C  in  16  ALU result carried through the MEM stage.
- d_datain  in  16  data-memory read data for the MEM-stage instruction.
- wb_ir  out  16  instruction in the WB stage (registered).
- reg_C1  out  16  WB-stage result value (registered).
- gr0..gr7  out  16 each  general registers, with write-through (see Behaviour).
- retire_cnt  out  RETIRE_W  count of non-NOP instructions that completed WB.
- halted  out  1  set once a `HALT reaches WB.

Behaviour:
- Reset (reset == 0, asynchronous): wb_ir, reg_C1, all eight stored registers, retire_cnt and halted are all 0. Takes effect mid-operation; any pending write is lost.
- Writing opcodes (wr_en set): `LDIH, `ADD, `ADDI, `ADDC, `SUB, `SUBI, `SUBC, `AND, `OR, `XOR, `SLL, `SRL, `SLA, `SRA, `LOAD.
- Non-writing opcodes: `CMP, `STORE, branches, `JMPR, `JUMP, `NOP, `HALT, and any undefined opcode.
- Destination register is always ir[10:8].
- Rising edge with state == `exec, all of the following happen in the same edge:
  - wb_ir <= mem_ir.
  - reg_C1 <= d_datain if mem_ir[15:11] == `LOAD, else reg_C.
  - Commit: if wb_ir (the pre-edge value) is a writing opcode, stored gr[wb_ir[10:8]] <= reg_C1 (pre-edge value).
  - retire_cnt increments if pre-edge wb_ir != 16'h0000 (NOP/bubble).
  - halted <= 1 if pre-edge wb_ir[15:11] == `HALT. Sticky until reset.
- Rising edge with state != `exec: all registers hold; no commit, no count.
- Write-through outputs, combinational:
  - grN = reg_C1 when wb_ir is a writing opcode and wb_ir[10:8] == N; otherwise grN = stored gr[N].
  - Decode therefore reads a correct value when a `LOAD (or ALU op) sits in WB in the same cycle.
- gr0 is an ordinary writable register (not hardwired zero).
- Latency:
  - MEM-to-WB: 1 cycle.
  - Value visible on grN: same cycle the instruction is in WB (write-through).
  - Value in stored array: 1 cycle later.
- Back-to-back writes to the same register: stored value follows program order; the write-through value always reflects the younger (WB) instruction.
- retire_cnt wraps from all-ones to 0 with no flag.
- `HALT in WB counts as retired; halted is visible the cycle after `HALT leaves WB.
- Bubbles (mem_ir == 0) propagate normally and neither write nor count.

Decomposition:
- Opcode macros and `exec come from the shared define.v; no new constants.
- Add a macro-level list of writing opcodes to define.v so decode-stage hazard logic and this block share one definition.
- One natural sub-module: wb_dest_decode (combinational). Input ir[15:0]; outputs wr_en and dest[2:0]. Instantiated once on wb_ir.
- Register array and counters stay in wb_regfile.

Test Plan:
- Reset low mid-run with gr3 = 16'h1234 -> all outputs 0 immediately, asynchronously, without waiting for a clock edge.
- mem_ir = `ADDI to r2, reg_C = 16'h00A5, state = `exec -> next cycle wb_ir = mem_ir, reg_C1 = 16'h00A5, gr2 = 16'h00A5 (write-through). The following cycle gr2 is still 16'h00A5 from the stored array.
- mem_ir = `LOAD to r5, reg_C = 16'h0003, d_datain = 16'hBEEF -> reg_C1 = 16'hBEEF, gr5 = 16'hBEEF; retire_cnt increments by 1 after WB.
- mem_ir = `STORE using r1, then `CMP -> gr1 unchanged; retire_cnt increases by 2.
- state != `exec for 3 edges with an `ADD in MEM -> wb_ir, reg_C1, gr* and retire_cnt all unchanged. Resumes correctly when state == `exec.
- `ADD r4 (16'h0001) then `SUB r4 (16'h0002) back-to-back -> gr4 reads 1 then 2. `HALT following -> halted = 1 and stays 1. retire_cnt preset near all-ones wraps to 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared opcode map, run-state encoding and the writing-opcode list.
// Decode-stage hazard logic imports the same list.
package wb_regfile_pkg;

    localparam logic EXEC = 1'b1;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    // Anything not listed here (branches, CMP, STORE, undefined codes) never writes.
    function automatic logic is_wr_op(input logic [4:0] op);
        logic wr;
        wr = 1'b0;
        case (op)
            OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
            OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA,
            OP_LOAD: wr = 1'b1;
            default: wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/wb_dest_decode.sv
// Write-enable and destination field decode for a WB-stage instruction.
module wb_dest_decode
    import wb_regfile_pkg::*;
(
    input  logic [15:0] ir,
    output logic        wr_en,
    output logic [2:0]  dest
);

    assign wr_en = is_wr_op(ir[15:11]);
    assign dest  = ir[10:8];

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB pipeline registers, general register file with write-through reads,
// retired-instruction counter and sticky halt flag.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                state,
    input  logic [15:0]         mem_ir,
    input  logic [15:0]         reg_C,
    input  logic [15:0]         d_datain,
    output logic [15:0]         wb_ir,
    output logic [15:0]         reg_C1,
    output logic [15:0]         gr0,
    output logic [15:0]         gr1,
    output logic [15:0]         gr2,
    output logic [15:0]         gr3,
    output logic [15:0]         gr4,
    output logic [15:0]         gr5,
    output logic [15:0]         gr6,
    output logic [15:0]         gr7,
    output logic [RETIRE_W-1:0] retire_cnt,
    output logic                halted
);

    logic        wr_en;
    logic [2:0]  dest;
    logic [15:0] gr_q  [8];
    logic [15:0] gr_rd [8];

    wb_dest_decode u_dest (
        .ir    (wb_ir),
        .wr_en (wr_en),
        .dest  (dest)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_ir      <= '0;
            reg_C1     <= '0;
            retire_cnt <= '0;
            halted     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                gr_q[i] <= '0;
            end
        end else if (state == EXEC) begin
            wb_ir  <= mem_ir;
            reg_C1 <= (mem_ir[15:11] == OP_LOAD) ? d_datain : reg_C;
            // Commit and bookkeeping act on the instruction leaving WB.
            if (wr_en) begin
                gr_q[dest] <= reg_C1;
            end
            if (wb_ir != 16'h0000) begin
                retire_cnt <= retire_cnt + RETIRE_W'(1);
            end
            if (wb_ir[15:11] == OP_HALT) begin
                halted <= 1'b1;
            end
        end
    end

    // Forward the WB result so decode sees it in the same cycle.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            gr_rd[i] = (wr_en && (dest == 3'(i))) ? reg_C1 : gr_q[i];
        end
    end

    assign gr0 = gr_rd[0];
    assign gr1 = gr_rd[1];
    assign gr2 = gr_rd[2];
    assign gr3 = gr_rd[3];
    assign gr4 = gr_rd[4];
    assign gr5 = gr_rd[5];
    assign gr6 = gr_rd[6];
    assign gr7 = gr_rd[7];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; narrow retire counter so wrap is reachable.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    localparam int RW = 4;

    logic          clock;
    logic          reset;
    logic          state;
    logic [15:0]   mem_ir;
    logic [15:0]   reg_C;
    logic [15:0]   d_datain;
    logic [15:0]   wb_ir;
    logic [15:0]   reg_C1;
    logic [15:0]   gr [8];
    logic [RW-1:0] retire_cnt;
    logic          halted;

    int total = 0;
    int bad   = 0;

    wb_regfile #(.RETIRE_W(RW)) dut (
        .clock      (clock),
        .reset      (reset),
        .state      (state),
        .mem_ir     (mem_ir),
        .reg_C      (reg_C),
        .d_datain   (d_datain),
        .wb_ir      (wb_ir),
        .reg_C1     (reg_C1),
        .gr0        (gr[0]),
        .gr1        (gr[1]),
        .gr2        (gr[2]),
        .gr3        (gr[3]),
        .gr4        (gr[4]),
        .gr5        (gr[5]),
        .gr6        (gr[6]),
        .gr7        (gr[7]),
        .retire_cnt (retire_cnt),
        .halted     (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [2:0] rd);
        return {op, rd, 8'h00};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; state = EXEC; mem_ir = '0; reg_C = '0; d_datain = '0;
        #1;
        total++; if (wb_ir !== 16'h0) begin bad++; $display("FAIL reset_wb_ir got=%h want=0000", wb_ir); end
        total++; if (reg_C1 !== 16'h0) begin bad++; $display("FAIL reset_reg_C1 got=%h want=0000", reg_C1); end
        total++; if (retire_cnt !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", retire_cnt); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        for (int i = 0; i < 8; i++) begin
            total++; if (gr[i] !== 16'h0) begin bad++; $display("FAIL reset_gr%0d got=%h want=0000", i, gr[i]); end
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_addi();
        mem_ir = ins(OP_ADDI, 3'd2); reg_C = 16'h00A5; d_datain = 16'hFFFF;
        step();
        total++; if (wb_ir !== ins(OP_ADDI, 3'd2)) begin bad++; $display("FAIL addi_wb_ir got=%h want=%h", wb_ir, ins(OP_ADDI, 3'd2)); end
        total++; if (reg_C1 !== 16'h00A5) begin bad++; $display("FAIL addi_reg_C1 got=%h want=00a5", reg_C1); end
        total++; if (gr[2] !== 16'h00A5) begin bad++; $display("FAIL addi_wt_gr2 got=%h want=00a5", gr[2]); end
        total++; if (retire_cnt !== 4'd0) begin bad++; $display("FAIL addi_cnt0 got=%0d want=0", retire_cnt); end
        mem_ir = '0; reg_C = 16'h1111;
        step();
        total++; if (gr[2] !== 16'h00A5) begin bad++; $display("FAIL addi_stored_gr2 got=%h want=00a5", gr[2]); end
        total++; if (retire_cnt !== 4'd1) begin bad++; $display("FAIL addi_cnt1 got=%0d want=1", retire_cnt); end
    endtask

    task automatic test_load();
        mem_ir = ins(OP_LOAD, 3'd5); reg_C = 16'h0003; d_datain = 16'hBEEF;
        step();
        total++; if (reg_C1 !== 16'hBEEF) begin bad++; $display("FAIL load_reg_C1 got=%h want=beef", reg_C1); end
        total++; if (gr[5] !== 16'hBEEF) begin bad++; $display("FAIL load_wt_gr5 got=%h want=beef", gr[5]); end
        total++; if (retire_cnt !== 4'd1) begin bad++; $display("FAIL load_cnt_pre got=%0d want=1", retire_cnt); end
        mem_ir = '0; reg_C = 16'h2222;
        step();
        total++; if (gr[5] !== 16'hBEEF) begin bad++; $display("FAIL load_stored_gr5 got=%h want=beef", gr[5]); end
        total++; if (retire_cnt !== 4'd2) begin bad++; $display("FAIL load_cnt got=%0d want=2", retire_cnt); end
    endtask

    task automatic test_store_cmp();
        mem_ir = ins(OP_STORE, 3'd1); reg_C = 16'h7777;
        step();
        total++; if (gr[1] !== 16'h0) begin bad++; $display("FAIL store_gr1 got=%h want=0000", gr[1]); end
        mem_ir = ins(OP_CMP, 3'd1); reg_C = 16'h8888;
        step();
        total++; if (gr[1] !== 16'h0) begin bad++; $display("FAIL cmp_gr1 got=%h want=0000", gr[1]); end
        total++; if (retire_cnt !== 4'd3) begin bad++; $display("FAIL store_cnt got=%0d want=3", retire_cnt); end
        mem_ir = '0;
        step();
        total++; if (gr[1] !== 16'h0) begin bad++; $display("FAIL cmp_stored_gr1 got=%h want=0000", gr[1]); end
        total++; if (retire_cnt !== 4'd4) begin bad++; $display("FAIL cmp_cnt got=%0d want=4", retire_cnt); end
    endtask

    task automatic test_stall();
        mem_ir = ins(OP_ADD, 3'd6); reg_C = 16'h0042; state = ~EXEC;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (wb_ir !== 16'h0) begin bad++; $display("FAIL stall_wb_ir%0d got=%h want=0000", k, wb_ir); end
            total++; if (reg_C1 !== 16'h8888) begin bad++; $display("FAIL stall_reg_C1%0d got=%h want=8888", k, reg_C1); end
            total++; if (gr[6] !== 16'h0) begin bad++; $display("FAIL stall_gr6%0d got=%h want=0000", k, gr[6]); end
            total++; if (retire_cnt !== 4'd4) begin bad++; $display("FAIL stall_cnt%0d got=%0d want=4", k, retire_cnt); end
        end
        state = EXEC;
        step();
        total++; if (wb_ir !== ins(OP_ADD, 3'd6)) begin bad++; $display("FAIL resume_wb_ir got=%h want=%h", wb_ir, ins(OP_ADD, 3'd6)); end
        total++; if (gr[6] !== 16'h0042) begin bad++; $display("FAIL resume_gr6 got=%h want=0042", gr[6]); end
        mem_ir = '0;
        step();
        total++; if (gr[6] !== 16'h0042) begin bad++; $display("FAIL resume_stored_gr6 got=%h want=0042", gr[6]); end
        total++; if (retire_cnt !== 4'd5) begin bad++; $display("FAIL resume_cnt got=%0d want=5", retire_cnt); end
    endtask

    task automatic test_back_to_back();
        mem_ir = ins(OP_ADD, 3'd4); reg_C = 16'h0001;
        step();
        total++; if (gr[4] !== 16'h0001) begin bad++; $display("FAIL b2b_gr4_first got=%h want=0001", gr[4]); end
        mem_ir = ins(OP_SUB, 3'd4); reg_C = 16'h0002;
        step();
        total++; if (gr[4] !== 16'h0002) begin bad++; $display("FAIL b2b_gr4_second got=%h want=0002", gr[4]); end
        mem_ir = ins(OP_HALT, 3'd4); reg_C = 16'h0009;
        step();
        total++; if (gr[4] !== 16'h0002) begin bad++; $display("FAIL b2b_gr4_stored got=%h want=0002", gr[4]); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b want=0", halted); end
        total++; if (retire_cnt !== 4'd7) begin bad++; $display("FAIL b2b_cnt got=%0d want=7", retire_cnt); end
        mem_ir = '0;
        step();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%b want=1", halted); end
        total++; if (retire_cnt !== 4'd8) begin bad++; $display("FAIL halt_cnt got=%0d want=8", retire_cnt); end
        step();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b want=1", halted); end
    endtask

    task automatic test_wrap();
        mem_ir = ins(OP_ADDI, 3'd7);
        for (int k = 0; k < 8; k++) begin
            reg_C = 16'(16'h0100 + k);
            step();
        end
        total++; if (retire_cnt !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%0d want=15", retire_cnt); end
        total++; if (gr[7] !== 16'h0107) begin bad++; $display("FAIL wrap_gr7 got=%h want=0107", gr[7]); end
        mem_ir = '0;
        step();
        total++; if (retire_cnt !== 4'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", retire_cnt); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL wrap_halted got=%b want=1", halted); end
    endtask

    task automatic test_async_reset();
        mem_ir = ins(OP_ADD, 3'd3); reg_C = 16'h1234;
        step();
        mem_ir = ins(OP_XOR, 3'd1); reg_C = 16'h5A5A;
        step();
        total++; if (gr[3] !== 16'h1234) begin bad++; $display("FAIL pre_reset_gr3 got=%h want=1234", gr[3]); end
        #2 reset = 1'b0;
        #1;
        total++; if (wb_ir !== 16'h0) begin bad++; $display("FAIL areset_wb_ir got=%h want=0000", wb_ir); end
        total++; if (reg_C1 !== 16'h0) begin bad++; $display("FAIL areset_reg_C1 got=%h want=0000", reg_C1); end
        total++; if (retire_cnt !== 4'h0) begin bad++; $display("FAIL areset_cnt got=%0d want=0", retire_cnt); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL areset_halted got=%b want=0", halted); end
        for (int i = 0; i < 8; i++) begin
            total++; if (gr[i] !== 16'h0) begin bad++; $display("FAIL areset_gr%0d got=%h want=0000", i, gr[i]); end
        end
        #2 reset = 1'b1;
    endtask

    task automatic test_gr0_and_undef();
        mem_ir = ins(OP_ADD, 3'd0); reg_C = 16'h5555;
        step();
        total++; if (gr[0] !== 16'h5555) begin bad++; $display("FAIL gr0_wt got=%h want=5555", gr[0]); end
        mem_ir = {5'b10011, 3'd0, 8'h00}; reg_C = 16'hDEAD;
        step();
        total++; if (gr[0] !== 16'h5555) begin bad++; $display("FAIL gr0_stored got=%h want=5555", gr[0]); end
        mem_ir = ins(OP_BZ, 3'd0); reg_C = 16'hCAFE;
        step();
        total++; if (gr[0] !== 16'h5555) begin bad++; $display("FAIL undef_gr0 got=%h want=5555", gr[0]); end
        total++; if (retire_cnt !== 4'd2) begin bad++; $display("FAIL undef_cnt got=%0d want=2", retire_cnt); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_store_cmp();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_gr0_and_undef();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
